regfile_scoreboard: RTL and testbench
=====================================

# regfile_scoreboard

Parametrised successor to the processor's 32×32 register file: a depth-, width- and read-port-configurable register array with write-to-read bypass, optional hardwired register 0, and a per-register scoreboard of pending writes. It sits in the decode stage. Operand reads and hazard status for every read port come out in the same cycle, so the pipeline can stall on a busy source without a separate hazard unit.

## Interface
Parameters:
- DATA_WIDTH, 32, bits per register
- ADDR_WIDTH, 5, register index width; depth = 2**ADDR_WIDTH
- NUM_READ, 2, number of independent read ports (≥1)
- ZERO_REG, 1, 1 = register 0 reads as 0, ignores writes, never busy
- BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports

Ports:
- clock  in  1  single clock, all state updates on rising edge
- ctrl_reset_n  in  1  synchronous, active-low reset
- ctrl_writeEnable  in  1  commit data_writeReg to ctrl_writeReg this edge
- ctrl_writeReg  in  ADDR_WIDTH  write index
- data_writeReg  in  DATA_WIDTH  write data
- ctrl_reserveEnable  in  1  mark ctrl_reserveReg as pending (issued producer)
- ctrl_reserveReg  in  ADDR_WIDTH  reserve index
- ctrl_readReg  in  NUM_READ*ADDR_WIDTH  read indices, port k at [k*ADDR_WIDTH +: ADDR_WIDTH]
- data_readReg  out  NUM_READ*DATA_WIDTH  read data, port k at [k*DATA_WIDTH +: DATA_WIDTH]
- read_busy  out  NUM_READ  1 = port k's register has a pending write
- busy_count  out  ADDR_WIDTH+1  number of registers currently busy (registered)

## Operation
- Storage: 2**ADDR_WIDTH × DATA_WIDTH flops, plus one busy bit per register.
- Reset (ctrl_reset_n=0 at an edge): all registers 0, all busy bits 0, busy_count 0. Reset overrides write and reserve in the same cycle.
- Write: when ctrl_writeEnable=1 at an edge, reg[ctrl_writeReg] ← data_writeReg, and busy[ctrl_writeReg] ← 0 unless it is re-reserved in the same cycle.
- Reserve: when ctrl_reserveEnable=1 at an edge, busy[ctrl_reserveReg] ← 1.
- Write and reserve to the same index in the same cycle: data is written and busy ends at 1. The newer producer wins.
- ZERO_REG=1: writes and reserves to index 0 are ignored; reg0 reads 0 and busy0 stays 0, even with bypass.
- Reads are combinational.
  - data_readReg[k] = reg[ctrl_readReg[k]].
  - With BYPASS=1, ctrl_writeEnable=1 and ctrl_writeReg==ctrl_readReg[k], the port returns data_writeReg instead.
- read_busy[k] = busy[ctrl_readReg[k]], combinational.
  - With BYPASS=1, it is forced to 0 when a write to that index is presented this cycle.
  - A reserve presented this cycle does not affect read_busy until the next cycle.
- busy_count tracks the popcount of the busy bits as registered state.
  - Net change per edge ∈ {−1, 0, +1}: +1 for a reserve of a non-busy register, −1 for a write clearing a busy register.
  - Reserve of an already-busy register: no change.
  - Write to a non-busy register: no change.
  - Write and reserve to the same busy index: no change.
  - Write and reserve to the same non-busy index: +1.
  - Maximum value is 2**ADDR_WIDTH − ZERO_REG, so the counter never wraps.
- Any number of read ports may address the same register and receive identical data.

## Timing
- Write latency: 1 edge to storage, 0 cycles to readers when BYPASS=1, 1 cycle when BYPASS=0.
- Reserve latency: busy visible on read_busy and busy_count in the cycle after the edge.
- Clear latency: busy drops in the cycle after the write edge. With BYPASS=1, read_busy drops in the write cycle itself.
- Outputs in the first cycle after reset: data_readReg all 0, read_busy all 0, busy_count 0.
- Reset asserted mid-operation (pending reserves outstanding): all state is cleared at that edge, and outstanding producers are forgotten.
- No combinational path from read indices to any registered state.

## Test plan
- Reset, then write 0xDEADBEEF to r5. The next cycle, read r5 on both ports → 0xDEADBEEF on both; all other registers read 0.
- BYPASS=1: write 0x1234 to r7 while port 1 reads r7 in the same cycle → port 1 = 0x1234 in that cycle, read_busy[1]=0. Repeat with BYPASS=0 → old value 0 in the write cycle, 0x1234 the next cycle.
- ZERO_REG=1: write 0xFFFFFFFF and reserve r0 → r0 reads 0, read_busy=0, busy_count=0.
- Reserve r3, then r4 → busy_count 1, then 2; read_busy=1 on a port reading r3. Write r3 → read_busy drops in the write cycle (BYPASS=1) and busy_count=1 on the next cycle.
- Write and reserve r9 in the same cycle while r9 is busy → data updated, r9 still busy, busy_count unchanged.
- Reserve all 31 non-zero registers → busy_count=31. Pull ctrl_reset_n low for one edge → busy_count=0, all registers read 0, all read_busy=0.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// Decode-stage register file with write-to-read bypass, optional hardwired r0,
// and a per-register pending-write scoreboard reported alongside each operand read.
module regfile_scoreboard #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_READ   = 2,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1
) (
  input  logic                           clock,
  input  logic                           ctrl_reset_n,
  input  logic                           ctrl_writeEnable,
  input  logic [ADDR_WIDTH-1:0]          ctrl_writeReg,
  input  logic [DATA_WIDTH-1:0]          data_writeReg,
  input  logic                           ctrl_reserveEnable,
  input  logic [ADDR_WIDTH-1:0]          ctrl_reserveReg,
  input  logic [NUM_READ*ADDR_WIDTH-1:0] ctrl_readReg,
  output logic [NUM_READ*DATA_WIDTH-1:0] data_readReg,
  output logic [NUM_READ-1:0]            read_busy,
  output logic [ADDR_WIDTH:0]            busy_count
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int CW    = ADDR_WIDTH + 1;

  logic [DATA_WIDTH-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0]      busy_q, busy_d;
  logic [CW-1:0]         busy_count_q, busy_count_d;

  logic wr_eff, res_eff, cnt_inc, cnt_dec;

  // Index 0 is inert for both writes and reserves when it is hardwired.
  assign wr_eff  = ctrl_writeEnable   && !(ZERO_REG != 0 && ctrl_writeReg   == '0);
  assign res_eff = ctrl_reserveEnable && !(ZERO_REG != 0 && ctrl_reserveReg == '0);

  always_comb begin
    busy_d = busy_q;
    if (wr_eff)  busy_d[ctrl_writeReg]   = 1'b0;
    if (res_eff) busy_d[ctrl_reserveReg] = 1'b1;
  end

  // A write that lands on the register being re-reserved never frees it.
  always_comb begin
    cnt_inc = res_eff && !busy_q[ctrl_reserveReg];
    cnt_dec = wr_eff && busy_q[ctrl_writeReg] &&
              !(res_eff && (ctrl_reserveReg == ctrl_writeReg));
    busy_count_d = busy_count_q + CW'(cnt_inc) - CW'(cnt_dec);
  end

  always_ff @(posedge clock) begin
    if (!ctrl_reset_n) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
      busy_q       <= '0;
      busy_count_q <= '0;
    end else begin
      if (wr_eff) regs_q[ctrl_writeReg] <= data_writeReg;
      busy_q       <= busy_d;
      busy_count_q <= busy_count_d;
    end
  end

  always_comb begin
    data_readReg = '0;
    read_busy    = '0;
    for (int k = 0; k < NUM_READ; k++) begin
      logic [ADDR_WIDTH-1:0] idx;
      logic [DATA_WIDTH-1:0] rdat;
      logic                  rbsy;
      idx  = ctrl_readReg[k*ADDR_WIDTH +: ADDR_WIDTH];
      rdat = regs_q[idx];
      rbsy = busy_q[idx];
      if (BYPASS != 0 && wr_eff && ctrl_writeReg == idx) begin
        rdat = data_writeReg;
        rbsy = 1'b0;
      end
      if (ZERO_REG != 0 && idx == '0) begin
        rdat = '0;
        rbsy = 1'b0;
      end
      data_readReg[k*DATA_WIDTH +: DATA_WIDTH] = rdat;
      read_busy[k]                             = rbsy;
    end
  end

  assign busy_count = busy_count_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: a bypassing and a non-bypassing instance
// share one stimulus stream; expected values go through a queue and are popped at each check.
module tb_regfile_scoreboard;

  logic        clock = 1'b0;
  logic        ctrl_reset_n;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;
  logic        ctrl_reserveEnable;
  logic [4:0]  ctrl_reserveReg;
  logic [4:0]  rd0, rd1;
  logic [9:0]  ctrl_readReg;
  logic [63:0] data_readReg, nb_data_readReg;
  logic [1:0]  read_busy, nb_read_busy;
  logic [5:0]  busy_count, nb_busy_count;

  logic [31:0] exp_q[$];
  logic [31:0] model [32];
  int checks = 0;
  int errors = 0;

  assign ctrl_readReg = {rd1, rd0};

  always #5 clock = ~clock;

  regfile_scoreboard dut (
    .clock(clock), .ctrl_reset_n(ctrl_reset_n),
    .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg),
    .data_writeReg(data_writeReg), .ctrl_reserveEnable(ctrl_reserveEnable),
    .ctrl_reserveReg(ctrl_reserveReg), .ctrl_readReg(ctrl_readReg),
    .data_readReg(data_readReg), .read_busy(read_busy), .busy_count(busy_count)
  );

  regfile_scoreboard #(.BYPASS(0)) dut_nb (
    .clock(clock), .ctrl_reset_n(ctrl_reset_n),
    .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg),
    .data_writeReg(data_writeReg), .ctrl_reserveEnable(ctrl_reserveEnable),
    .ctrl_reserveReg(ctrl_reserveReg), .ctrl_readReg(ctrl_readReg),
    .data_readReg(nb_data_readReg), .read_busy(nb_read_busy), .busy_count(nb_busy_count)
  );

  function automatic logic [31:0] port(input logic [63:0] v, input int k);
    return v[k*32 +: 32];
  endfunction

  task automatic expect_val(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] exp;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s: observed %h with no expected value queued", tag, obs);
    end else begin
      exp = exp_q.pop_front();
      assert (obs === exp) else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
    end
  endtask

  task automatic idle();
    ctrl_writeEnable   = 1'b0;
    ctrl_writeReg      = '0;
    data_writeReg      = '0;
    ctrl_reserveEnable = 1'b0;
    ctrl_reserveReg    = '0;
  endtask

  task automatic drive_write(input logic [4:0] r, input logic [31:0] d);
    ctrl_writeEnable = 1'b1;
    ctrl_writeReg    = r;
    data_writeReg    = d;
  endtask

  task automatic drive_reserve(input logic [4:0] r);
    ctrl_reserveEnable = 1'b1;
    ctrl_reserveReg    = r;
  endtask

  initial begin
    ctrl_reset_n = 1'b0;
    idle();
    rd0 = 5'd5;
    rd1 = 5'd9;
    @(negedge clock);

    // Reset state
    ctrl_reset_n = 1'b1;
    #1;
    expect_val(32'h0); check("reset_p0", port(data_readReg, 0));
    expect_val(32'h0); check("reset_p1", port(data_readReg, 1));
    expect_val(32'h0); check("reset_busy", 32'(read_busy));
    expect_val(32'h0); check("reset_cnt", 32'(busy_count));

    // Write r5, read on both ports next cycle
    drive_write(5'd5, 32'hDEADBEEF);
    @(negedge clock);
    idle();
    rd0 = 5'd5; rd1 = 5'd5;
    #1;
    expect_val(32'hDEADBEEF); check("r5_p0", port(data_readReg, 0));
    expect_val(32'hDEADBEEF); check("r5_p1", port(data_readReg, 1));
    expect_val(32'hDEADBEEF); check("r5_nb_p1", port(nb_data_readReg, 1));
    rd0 = 5'd6; rd1 = 5'd31;
    #1;
    expect_val(32'h0); check("r6_zero", port(data_readReg, 0));
    expect_val(32'h0); check("r31_zero", port(data_readReg, 1));

    // Same-cycle bypass on port 1
    rd0 = 5'd5; rd1 = 5'd7;
    drive_write(5'd7, 32'h1234);
    #1;
    expect_val(32'h1234); check("bypass_p1", port(data_readReg, 1));
    expect_val(32'h0);    check("bypass_busy1", 32'(read_busy[1]));
    expect_val(32'h0);    check("nobypass_old", port(nb_data_readReg, 1));
    expect_val(32'hDEADBEEF); check("bypass_p0_other", port(data_readReg, 0));
    @(negedge clock);
    idle();
    #1;
    expect_val(32'h1234); check("nobypass_next", port(nb_data_readReg, 1));

    // Hardwired r0: write and reserve both ignored
    rd0 = 5'd0; rd1 = 5'd0;
    drive_write(5'd0, 32'hFFFFFFFF);
    drive_reserve(5'd0);
    #1;
    expect_val(32'h0); check("r0_bypass_data", port(data_readReg, 0));
    expect_val(32'h0); check("r0_bypass_busy", 32'(read_busy));
    @(negedge clock);
    idle();
    #1;
    expect_val(32'h0); check("r0_data", port(data_readReg, 1));
    expect_val(32'h0); check("r0_nb_data", port(nb_data_readReg, 1));
    expect_val(32'h0); check("r0_busy", 32'(read_busy));
    expect_val(32'h0); check("r0_cnt", 32'(busy_count));

    // Reserve r3 then r4
    drive_reserve(5'd3);
    @(negedge clock);
    idle();
    rd0 = 5'd3; rd1 = 5'd4;
    drive_reserve(5'd4);
    #1;
    expect_val(32'd1); check("cnt_after_r3", 32'(busy_count));
    expect_val(32'd1); check("busy_r3", 32'(read_busy[0]));
    expect_val(32'd0); check("busy_r4_same_cycle", 32'(read_busy[1]));
    @(negedge clock);
    idle();
    #1;
    expect_val(32'd2); check("cnt_after_r4", 32'(busy_count));
    expect_val(32'd1); check("busy_r4", 32'(read_busy[1]));

    // Write r3: bypass instance clears read_busy in the write cycle
    drive_write(5'd3, 32'h33);
    #1;
    expect_val(32'd0); check("clear_busy_bypass", 32'(read_busy[0]));
    expect_val(32'd1); check("clear_busy_nobypass", 32'(nb_read_busy[0]));
    @(negedge clock);
    idle();
    #1;
    expect_val(32'd1); check("cnt_after_clear", 32'(busy_count));
    expect_val(32'd0); check("busy_r3_cleared_nb", 32'(nb_read_busy[0]));
    expect_val(32'h33); check("r3_data", port(nb_data_readReg, 0));

    // Write+reserve r9 while busy: data updates, stays busy, count unchanged
    drive_reserve(5'd9);
    @(negedge clock);
    idle();
    #1;
    expect_val(32'd2); check("cnt_r9_reserved", 32'(busy_count));
    drive_write(5'd9, 32'h99);
    drive_reserve(5'd9);
    @(negedge clock);
    idle();
    rd0 = 5'd9;
    #1;
    expect_val(32'h99); check("r9_data", port(data_readReg, 0));
    expect_val(32'd1);  check("r9_busy", 32'(read_busy[0]));
    expect_val(32'd2);  check("r9_cnt", 32'(busy_count));

    // Write+reserve r12 while not busy: count +1
    drive_write(5'd12, 32'hC0C0);
    drive_reserve(5'd12);
    @(negedge clock);
    idle();
    rd1 = 5'd12;
    #1;
    expect_val(32'd3);     check("r12_cnt", 32'(busy_count));
    expect_val(32'd1);     check("r12_busy", 32'(read_busy[1]));
    expect_val(32'hC0C0);  check("r12_data", port(data_readReg, 1));

    // Reserve every non-zero register
    for (int r = 1; r < 32; r++) begin
      drive_reserve(5'(r));
      @(negedge clock);
    end
    idle();
    #1;
    expect_val(32'd31); check("cnt_full", 32'(busy_count));
    expect_val(32'd31); check("cnt_full_nb", 32'(nb_busy_count));

    // Reset overrides a concurrent write and reserve
    ctrl_reset_n = 1'b0;
    drive_write(5'd5, 32'hAAAA5555);
    drive_reserve(5'd6);
    @(negedge clock);
    ctrl_reset_n = 1'b1;
    idle();
    rd0 = 5'd5; rd1 = 5'd9;
    #1;
    expect_val(32'd0); check("rst2_cnt", 32'(busy_count));
    expect_val(32'd0); check("rst2_p0", port(data_readReg, 0));
    expect_val(32'd0); check("rst2_p1", port(data_readReg, 1));
    expect_val(32'd0); check("rst2_busy", 32'(read_busy));
    rd0 = 5'd6; rd1 = 5'd12;
    #1;
    expect_val(32'd0); check("rst2_busy_r6_r12", 32'(read_busy));
    expect_val(32'd0); check("rst2_r12", port(data_readReg, 1));

    // Random writes checked against a reference array the next cycle
    for (int i = 0; i < 32; i++) model[i] = '0;
    for (int i = 0; i < 10; i++) begin
      logic [4:0]  widx, ridx;
      logic [31:0] wdat;
      widx = 5'($urandom_range(31, 1));
      ridx = 5'($urandom_range(31, 0));
      wdat = $urandom;
      drive_write(widx, wdat);
      @(negedge clock);
      idle();
      model[widx] = wdat;
      rd0 = widx; rd1 = ridx;
      #1;
      expect_val(model[widx]); check("rand_p0", port(data_readReg, 0));
      expect_val(model[ridx]); check("rand_p1", port(data_readReg, 1));
      expect_val(model[ridx]); check("rand_nb_p1", port(nb_data_readReg, 1));
    end

    if (exp_q.size() != 0) begin
      errors++;
      $error("FAIL leftover: %0d expected values never compared, required 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
